// File: rtl/handshake_fork_stage.sv
// Ready/valid fork: 2-entry skid buffer feeding an eager N-way broadcast; a token retires once every lane has taken it.
// Optional retired-token counter on tok_count is enabled by defining HANDSHAKE_FORK_TOKCNT_EN.
module handshake_fork_stage #(
    parameter int WIDTH = 4,
    parameter int N     = 3,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef HANDSHAKE_FORK_TOKCNT_EN
    ,
    output logic [CNT_W-1:0] tok_count
`endif
);

    logic             head_valid;
    logic [WIDTH-1:0] head_data;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic [N-1:0]     done;

    logic [N-1:0]     lane_xfer;
    logic             in_xfer;
    logic             retire;

    // in_ready depends only on skid occupancy (and reset), never on out_ready.
    assign in_ready  = !skid_valid && !ASYNCRESET;
    assign out_valid = {N{head_valid}} & ~done;
    assign out_data  = head_data;

    assign lane_xfer = out_valid & out_ready;
    assign in_xfer   = in_valid && in_ready;
    assign retire    = head_valid && ((done | lane_xfer) == {N{1'b1}});

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the data registers are reset as well, so out_data is a known 0 after reset.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            head_valid <= 1'b0;
            head_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            done       <= '0;
        end else if (retire) begin
            done <= '0;
            if (skid_valid) begin
                head_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                head_data  <= in_data;
            end else begin
                head_valid <= 1'b0;
            end
        end else begin
            done <= done | lane_xfer;
            if (in_xfer) begin
                if (!head_valid) begin
                    head_valid <= 1'b1;
                    head_data  <= in_data;
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= in_data;
                end
            end
        end
    end

`ifdef HANDSHAKE_FORK_TOKCNT_EN
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            tok_count <= '0;
        end else if (retire) begin
            tok_count <= tok_count + 1'b1;
        end
    end
`endif

endmodule
